// File: rtl/alu_pipe.sv
// Registered, parametrised ALU with valid/ready handshakes and an iterative shift-add multiplier.
// Single-cycle ops retire on the acceptance edge; MUL runs WIDTH/MUL_STEP iterations, then one load cycle.
`timescale 1ns/1ps

module alu_pipe #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             add_sub,
    input  logic             ConstVar,
    input  logic [1:0]       LogicFn,
    input  logic [1:0]       ShiftFn,
    input  logic [2:0]       FnClass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             Overflow,
    output logic             busy
);

    localparam int unsigned SHW    = $clog2(WIDTH);
    localparam int unsigned N_ITER = WIDTH / MUL_STEP;
    localparam int unsigned CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned HALF   = WIDTH / 2;

    localparam logic [2:0] FN_LUI   = 3'b000;
    localparam logic [2:0] FN_SLT   = 3'b001;
    localparam logic [2:0] FN_SGT   = 3'b010;
    localparam logic [2:0] FN_ADD   = 3'b011;
    localparam logic [2:0] FN_LOGIC = 3'b100;
    localparam logic [2:0] FN_SHIFT = 3'b101;
    localparam logic [2:0] FN_HAM   = 3'b110;
    localparam logic [2:0] FN_MUL   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_d;
    logic             valid_d, ov_d, busy_d;
    logic [WIDTH-1:0] res_d;
    logic [PW-1:0]    acc, acc_d;
    logic [PW-1:0]    mcand, mcand_d;
    logic [WIDTH-1:0] mplier, mplier_d;
    logic [CW-1:0]    cnt, cnt_d;

    logic             accept;
    logic [WIDTH-1:0] op_res;
    logic             op_ov;

    logic [SHW-1:0]   sh_amt;
    logic [SHW:0]     rot_r;
    logic [WIDTH-1:0] y_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] lg_res;
    logic [WIDTH-1:0] sh_res;
    logic [WIDTH-1:0] pop;
    logic [PW-1:0]    partial;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath, evaluated on the operands presented at acceptance
    always_comb begin
        sh_amt = ConstVar ? SHW'(1) : y[SHW-1:0];
        rot_r  = (SHW+1)'(WIDTH) - (SHW+1)'(sh_amt);
        y_eff  = add_sub ? ~y : y;
        sum    = x + y_eff + WIDTH'(add_sub);

        case (LogicFn)
            2'b00:   lg_res = x & y;
            2'b01:   lg_res = x | y;
            2'b10:   lg_res = x ^ y;
            default: lg_res = ~(x | y);
        endcase

        // A rotate amount of 0 makes the right shift equal WIDTH, which yields 0
        case (ShiftFn)
            2'b00:   sh_res = x << sh_amt;
            2'b01:   sh_res = x >> sh_amt;
            2'b10:   sh_res = WIDTH'($signed(x) >>> sh_amt);
            default: sh_res = (x << sh_amt) | (x >> rot_r);
        endcase

        pop = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            pop = pop + WIDTH'(x[i]);
        end

        op_res = '0;
        op_ov  = 1'b0;
        case (FnClass)
            FN_LUI:   op_res = {y[HALF-1:0], {HALF{1'b0}}};
            FN_SLT:   op_res = WIDTH'($signed(x) < $signed(y));
            FN_SGT:   op_res = WIDTH'($signed(x) > $signed(y));
            FN_ADD: begin
                op_res = sum;
                op_ov  = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
            end
            FN_LOGIC: op_res = lg_res;
            FN_SHIFT: op_res = sh_res;
            FN_HAM:   op_res = pop;
            default:  op_res = '0;
        endcase
    end

    // Partial product for the MUL_STEP multiplier bits retired this iteration
    always_comb begin
        partial = '0;
        for (int j = 0; j < int'(MUL_STEP); j++) begin
            if (mplier[j]) begin
                partial = partial + (mcand << j);
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        valid_d  = out_valid;
        res_d    = ALU_result;
        ov_d     = Overflow;
        busy_d   = 1'b0;
        acc_d    = acc;
        mcand_d  = mcand;
        mplier_d = mplier;
        cnt_d    = cnt;

        if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    if (FnClass == FN_MUL) begin
                        state_d  = MUL;
                        busy_d   = 1'b1;
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, x};
                        mplier_d = y;
                        cnt_d    = '0;
                    end else begin
                        valid_d = 1'b1;
                        res_d   = op_res;
                        ov_d    = op_ov;
                    end
                end
            end
            MUL: begin
                busy_d   = 1'b1;
                acc_d    = acc + partial;
                mcand_d  = mcand << MUL_STEP;
                mplier_d = mplier >> MUL_STEP;
                cnt_d    = cnt + CW'(1);
                if (cnt == CW'(N_ITER - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                valid_d = 1'b1;
                res_d   = acc[WIDTH-1:0];
                ov_d    = |acc[PW-1:WIDTH];
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            ALU_result <= '0;
            Overflow   <= 1'b0;
            busy       <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_d;
            out_valid  <= valid_d;
            ALU_result <= res_d;
            Overflow   <= ov_d;
            busy       <= busy_d;
            acc        <= acc_d;
            mcand      <= mcand_d;
            mplier     <= mplier_d;
            cnt        <= cnt_d;
        end
    end

endmodule
